sram_controller: RTL and testbench

Sequences the 16-bit external SRAM (18-bit address, shared tri-state DQ, active-low strobes) for the ARM memory stage, which issues 32-bit word reads and writes. Each word access is split into two 16-bit SRAM accesses, low half then high half. While an access is in flight, `ready` stays low so the pipeline freezes. Sits between the MEM stage and the top-level SRAM pins.

---
 rtl/sram_ctrl_pkg.sv | 26 ++
 rtl/sram_wait_counter.sv | 50 +++++
 rtl/sram_controller.sv | 208 ++++++++++++++++++++
 tb/tb_sram_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared types and constants for the 32-bit-word to 16-bit-SRAM controller.
//   state_e            : controller FSM states (WAIT only reachable when the
//                        SRAM_WAIT_STATES_EN macro is defined)
//   SRAM_AW / SRAM_DW  : external SRAM half-word address / data widths
//   WORD_W             : width of the SRAM word index (one 32-bit CPU word)
//   DEFAULT_BASE_ADDR  : CPU byte address that maps to SRAM half-word 0
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  localparam int WORD_W  = SRAM_AW - 1;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// -----------------------------------------------------------------------------
// sram_wait_counter
// Loadable down-counter used to pad an SRAM word access with idle cycles.
// Only instantiated when SRAM_WAIT_STATES_EN is defined.
// Ports:
//   clk_i       : system clock
//   rst_i       : synchronous, active-high reset (clears the count)
//   load_i      : load load_val_i on the next edge (has priority over dec_i)
//   load_val_i  : value to load
//   dec_i       : decrement on the next edge, saturating at zero
//   zero_o      : count register is zero
// -----------------------------------------------------------------------------
module sram_wait_counter #(
  parameter int CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: load wins, otherwise saturating decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {CW{1'b0}})) begin
      cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
// Sequences a 16-bit asynchronous SRAM for 32-bit word accesses from the MEM
// stage. Each word access is two SRAM half-word accesses: low half at
// {word,0}, then high half at {word,1}. ready is low while an access is in
// flight so the pipeline freezes; it pulses high for one cycle in DONE.
//
// Optional feature (macro SRAM_WAIT_STATES_EN): inserts WAIT_CYCLES idle
// cycles after the high-half access. Without the macro WAIT_CYCLES is ignored.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   wr_en, rd_en        : word write / read request (write wins if both)
//   address             : CPU byte address (BASE_ADDR maps to SRAM word 0)
//   write_data          : word to write
//   read_data           : last word read, valid when ready=1 after a read
//   ready               : 0 = freeze pipeline
//   SRAM_DQ             : shared SRAM data bus (driven only while WE_N=0)
//   SRAM_ADDR           : SRAM half-word address
//   SRAM_UB_N/LB_N/CE_N/OE_N : tied active (0)
//   SRAM_WE_N           : write strobe, active low
// -----------------------------------------------------------------------------
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N
);

  state_e              state_q, state_d;
  logic                wr_q, wr_d;          // latched op: 1 = write
  logic [WORD_W-1:0]   word_q, word_d;      // latched SRAM word index
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [SRAM_AW-1:0]  addr_q, addr_d;

  logic [31:0]         off_s;
  logic                req_s;
  logic                we_n_s;
  logic [SRAM_DW-1:0]  dq_out_s;
  logic                wait_load_s;
  logic                wait_zero_s;
  logic                unused_addr_s;

  // Offset wraps at 32 bits; only bits [18:2] select the word, the rest is
  // dropped so out-of-range addresses alias silently.
  assign off_s         = address - BASE_ADDR;
  assign req_s         = wr_en | rd_en;
  assign unused_addr_s = ^{off_s[31:19], off_s[1:0]};

`ifdef SRAM_WAIT_STATES_EN
  localparam int WAIT_CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  // The counter is checked in the same cycle it is first seen in WAIT, so
  // loading N-1 yields exactly N WAIT cycles.
  localparam logic [WAIT_CW-1:0] WAIT_LOAD =
    WAIT_CW'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  sram_wait_counter #(
    .CW (WAIT_CW)
  ) u_wait_counter (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (wait_load_s),
    .load_val_i (WAIT_LOAD),
    .dec_i      (state_q == WAIT),
    .zero_o     (wait_zero_s)
  );
`else
  logic unused_wait_s;
  assign wait_zero_s   = 1'b1;
  assign unused_wait_s = (WAIT_CYCLES != 0) ^ wait_load_s ^ wait_zero_s;
`endif

  // Next-state, request latching and read-data capture.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    wait_load_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          wr_d    = wr_en;
          word_d  = off_s[18:2];
          wdata_d = write_data;
          addr_d  = {off_s[18:2], 1'b0};
          state_d = LO;
        end else begin
          state_d = IDLE;
        end
      end
      LO: begin
        if (!wr_q) begin
          rdata_d[15:0] = SRAM_DQ;
        end else begin
          rdata_d = rdata_q;
        end
        addr_d  = {word_q, 1'b1};
        state_d = HI;
      end
      HI: begin
        if (!wr_q) begin
          rdata_d[31:16] = SRAM_DQ;
        end else begin
          rdata_d = rdata_q;
        end
`ifdef SRAM_WAIT_STATES_EN
        if (WAIT_CYCLES > 0) begin
          wait_load_s = 1'b1;
          state_d     = WAIT;
        end else begin
          state_d = DONE;
        end
`else
        state_d = DONE;
`endif
      end
      WAIT: begin
        if (wait_zero_s) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      word_q  <= {WORD_W{1'b0}};
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      addr_q  <= {SRAM_AW{1'b0}};
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
    end
  end

  // Strobe, bus data and ready decode; WE_N and the DQ enable depend on the
  // state register only, so the bus is never driven outside LO/HI writes.
  always_comb begin
    we_n_s   = 1'b1;
    dq_out_s = wdata_q[15:0];
    ready    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = ~req_s;
      end
      LO: begin
        we_n_s   = ~wr_q;
        dq_out_s = wdata_q[15:0];
      end
      HI: begin
        we_n_s   = ~wr_q;
        dq_out_s = wdata_q[31:16];
      end
      DONE: begin
        ready = 1'b1;
      end
      default: begin
        we_n_s = 1'b1;
      end
    endcase
  end

  assign SRAM_DQ   = we_n_s ? 16'hzzzz : dq_out_s;
  assign SRAM_WE_N = we_n_s;
  assign SRAM_ADDR = addr_q;
  assign read_data = rdata_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
// Directed + random word accesses against an SRAM pin model. Expected results
// come from a word-level reference memory; a monitor process checks each
// access (timing, pin activity, read data) against a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_sram_controller;

  localparam logic [31:0] BASE = 32'd1024;
`ifdef SRAM_WAIT_STATES_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        ub_n, lb_n, ce_n, oe_n, we_n;

  sram_controller #(
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (sram_dq),
    .SRAM_ADDR  (sram_addr),
    .SRAM_UB_N  (ub_n),
    .SRAM_LB_N  (lb_n),
    .SRAM_CE_N  (ce_n),
    .SRAM_OE_N  (oe_n),
    .SRAM_WE_N  (we_n)
  );

  // SRAM pin model: asynchronous read, write latched at the clock edge.
  logic [15:0] mem [0:262143];
  assign sram_dq = (we_n && !oe_n) ? mem[sram_addr] : 16'hzzzz;
  always @(posedge clk) begin
    if (!we_n) mem[sram_addr] <= sram_dq;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: word index -> 32-bit word.
  logic [31:0] ref_mem [int unsigned];
  int unsigned pool [$];

  function automatic int unsigned word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off / 4) % 131072;
  endfunction

  typedef struct {
    bit          wr;
    logic [31:0] data;
    logic [17:0] lo;
    int unsigned issue;
  } entry_t;
  entry_t sb [$];

  // Monitor: tracks each access from its first ready=0 cycle to its ready pulse.
  bit          in_flight = 1'b0;
  int          k = 0;
  entry_t      cur;
  logic [31:0] last_rd = 32'd0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (in_flight) void'(sb.pop_front());
        in_flight = 1'b0;
        last_rd   = 32'd0;
      end else if (!in_flight) begin
        if (!ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_access", 32'd1, 32'd0);
          end else begin
            cur       = sb[0];
            in_flight = 1'b1;
            k         = 0;
            chk("start_cycle", cyc, cur.issue);
            chk("we_n_cycle0", {31'd0, we_n}, 32'd1);
          end
        end
      end else begin
        k++;
        if (ready) begin
          void'(sb.pop_front());
          in_flight = 1'b0;
          chk("latency", k, LAT);
          chk("we_n_done", {31'd0, we_n}, 32'd1);
          if (!cur.wr) last_rd = cur.data;
          chk(cur.wr ? "read_data_hold" : "read_data", read_data, last_rd);
        end else if (k <= 2) begin
          chk("sram_addr", {14'd0, sram_addr}, {14'd0, cur.lo + 18'(k - 1)});
          chk("we_n_access", {31'd0, we_n}, {31'd0, ~cur.wr});
          if (cur.wr) chk("dq_write", {16'd0, sram_dq},
                          {16'd0, (k == 1) ? cur.data[15:0] : cur.data[31:16]});
        end else if (k <= LAT) begin
          chk("we_n_wait", {31'd0, we_n}, 32'd1);
        end else begin
          chk("ready_overdue", {31'd0, ready}, 32'd1);
          void'(sb.pop_front());
          in_flight = 1'b0;
        end
      end
    end
  end

  // Issue one access at posedge+2 of an IDLE cycle; return at posedge+2 of
  // the cycle after the ready pulse.
  task automatic access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    entry_t      e;
    int unsigned idx;
    int          n;
    idx     = word_of(a);
    e.wr    = w;
    e.lo    = 18'(idx * 2);
    e.issue = cyc;
    if (w) begin
      e.data = d;
      ref_mem[idx] = d;
      pool.push_back(idx);
    end else begin
      e.data = ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
    end
    sb.push_back(e);
    wr_en = w; rd_en = r; address = a; write_data = d;
    @(posedge clk); #2;
    // Request inputs must be ignored once the access has started.
    wr_en = 1'b0; rd_en = 1'b0; address = $urandom; write_data = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 20);
    if (!ready) chk("access_timeout", {31'd0, ready}, 32'd1);
    @(posedge clk); #2;
  endtask

  initial begin
    logic [31:0] a;
    int unsigned idx;
    int          op;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_we_n", {31'd0, we_n}, 32'd1);
    chk("reset_addr", {14'd0, sram_addr}, 32'd0);
    chk("reset_read_data", read_data, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("tied_strobes", {28'd0, ub_n, lb_n, ce_n, oe_n}, 32'd0);
    @(posedge clk); #2;

    // Directed cases.
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    chk("mem0_beef", {16'd0, mem[0]}, 32'h0000BEEF);
    chk("mem1_dead", {16'd0, mem[1]}, 32'h0000DEAD);
    access(1'b1, 1'b0, 32'd1036, 32'h12345678);
    access(1'b0, 1'b1, 32'd1036, 32'd0);
    access(1'b1, 1'b0, 32'd1028, 32'h0BADF00D);   // back-to-back pair
    access(1'b0, 1'b1, 32'd1028, 32'd0);
    access(1'b1, 1'b1, 32'd1040, 32'hA5A55A5A);   // write wins
    chk("mem8", {16'd0, mem[8]}, 32'h00005A5A);
    chk("mem9", {16'd0, mem[9]}, 32'h0000A5A5);
    repeat (2) begin @(posedge clk); #2; end

    // Reset during the low-half write: low half lands, high half never does.
    begin
      entry_t e;
      e.wr = 1'b1; e.data = 32'hCAFEF00D; e.lo = 18'd0; e.issue = cyc;
      sb.push_back(e);
      ref_mem[0] = {ref_mem[0][31:16], 16'hF00D};
      wr_en = 1'b1; address = 32'd1024; write_data = 32'hCAFEF00D;
      @(posedge clk); #2;
      wr_en = 1'b0;
      rst   = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_we_n", {31'd0, we_n}, 32'd1);
      chk("rst_mid_ready", {31'd0, ready}, 32'd1);
      chk("rst_mid_read_data", read_data, 32'd0);
      chk("rst_mid_mem0", {16'd0, mem[0]}, 32'h0000F00D);
      chk("rst_mid_mem1", {16'd0, mem[1]}, 32'h0000DEAD);
      @(posedge clk); #2;
    end
    access(1'b0, 1'b1, 32'd1024, 32'd0);          // reads {DEAD,F00D}
    access(1'b0, 1'b1, 32'd1036, 32'd0);

    // Random mix with aliasing addresses and variable idle gaps.
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      if (op == 1) begin
        idx = pool[$urandom_range(0, pool.size() - 1)];
        a   = BASE + idx * 4 + $urandom_range(0, 3);
        if ($urandom_range(0, 1) == 1) a = a + 32'h0008_0000 * $urandom_range(1, 7);
        access(1'b0, 1'b1, a, $urandom);
      end else begin
        case ($urandom_range(0, 2))
          0:       a = BASE + 4 * $urandom_range(0, 63) + $urandom_range(0, 3);
          1:       a = BASE - 4 * $urandom_range(1, 8);
          default: a = BASE + 32'h0010_0000 * $urandom_range(1, 15) + 4 * $urandom_range(0, 63);
        endcase
        access(1'b1, op == 2, a, $urandom);
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
